// File: rtl/pool_mc_if.sv
// Window-beat input stream, runtime configuration and result stream of pool_mc.
// The master drives beats and config; the slave reduces windows and returns results.
interface pool_mc_if #(
  parameter int DATA_W = 32,
  parameter int WIN    = 5,
  parameter int CH     = 4
);
  logic [$clog2(WIN+1)-1:0] kernel_width;
  logic [1:0]               pool_mode;
  logic [4:0]               mean_shift;
  logic                     in_valid;
  logic                     in_ready;
  logic [CH*WIN*DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [CH*DATA_W-1:0]     out_data;
  logic                     busy;

  modport master (
    output kernel_width, pool_mode, mean_shift, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  kernel_width, pool_mode, mean_shift, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/pool_mc.sv
// Multi-channel pooling engine: reduces a K x K window per channel (max/min/sum/mean)
// from K row beats, with a one-entry output register and full backpressure.
module pool_mc #(
  parameter int DATA_W = 32,
  parameter int WIN    = 5,
  parameter int CH     = 4
) (
  input  logic     clk,
  input  logic     rst,
  pool_mc_if.slave bus
);
  localparam int ACC_W = DATA_W + $clog2(WIN*WIN);
  localparam int KW_W  = $clog2(WIN+1);

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t SAT_MAX = acc_t'({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam acc_t SAT_MIN = acc_t'({{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});

  function automatic acc_t combine(input logic [1:0] mode, input acc_t a, input acc_t b);
    case (mode)
      2'd0:    combine = (a > b) ? a : b;
      2'd1:    combine = (a < b) ? a : b;
      default: combine = a + b;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] saturate(input acc_t v);
    if (v > SAT_MAX)      saturate = SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN) saturate = SAT_MIN[DATA_W-1:0];
    else                  saturate = v[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] finalise(input logic [1:0] mode, input logic [4:0] shift,
                                                 input acc_t v);
    case (mode)
      2'd0, 2'd1: finalise = v[DATA_W-1:0];
      2'd2:       finalise = saturate(v);
      2'd3:       finalise = saturate(v >>> shift);
      default:    finalise = v[DATA_W-1:0];
    endcase
  endfunction

  logic [KW_W-1:0]     beat_cnt_r;
  logic [KW_W-1:0]     cfg_k_r;
  logic [1:0]          cfg_mode_r;
  logic [4:0]          cfg_shift_r;
  acc_t                acc_r [CH];
  logic                out_valid_r;
  logic [CH*DATA_W-1:0] out_data_r;

  logic [KW_W-1:0]     k_clamp_s;
  logic [KW_W-1:0]     k_eff_s;
  logic [1:0]          mode_eff_s;
  logic [4:0]          shift_eff_s;
  logic                first_s;
  logic                last_s;
  logic                in_ready_s;
  logic                accept_s;
  acc_t                ident_s;
  acc_t                elem_s;
  acc_t                row_s;
  logic signed [DATA_W-1:0] raw_s;
  acc_t                row_red_s [CH];
  acc_t                acc_next_s [CH];
  logic [CH*DATA_W-1:0] fin_s;

  assign first_s    = (beat_cnt_r == {KW_W{1'b0}});
  assign in_ready_s = !out_valid_r || bus.out_ready;
  assign accept_s   = bus.in_valid && in_ready_s;
  assign last_s     = (beat_cnt_r == KW_W'(k_eff_s - KW_W'(1)));

  // Effective config: live inputs on the first beat, latched copy afterwards.
  always_comb begin
    if (bus.kernel_width == {KW_W{1'b0}}) begin
      k_clamp_s = KW_W'(1);
    end else if (bus.kernel_width > KW_W'(WIN)) begin
      k_clamp_s = KW_W'(WIN);
    end else begin
      k_clamp_s = bus.kernel_width;
    end
    if (first_s) begin
      k_eff_s     = k_clamp_s;
      mode_eff_s  = bus.pool_mode;
      shift_eff_s = bus.mean_shift;
    end else begin
      k_eff_s     = cfg_k_r;
      mode_eff_s  = cfg_mode_r;
      shift_eff_s = cfg_shift_r;
    end
  end

  // Per-channel row reduce with masked elements, then accumulate and finalise.
  always_comb begin
    case (mode_eff_s)
      2'd0:    ident_s = SAT_MIN;
      2'd1:    ident_s = SAT_MAX;
      default: ident_s = {ACC_W{1'b0}};
    endcase
    elem_s = {ACC_W{1'b0}};
    row_s  = {ACC_W{1'b0}};
    raw_s  = {DATA_W{1'b0}};
    fin_s  = {(CH*DATA_W){1'b0}};
    for (int c = 0; c < CH; c++) begin
      row_s = {ACC_W{1'b0}};
      for (int e = 0; e < WIN; e++) begin
        raw_s = bus.in_data[(c*WIN+e)*DATA_W +: DATA_W];
        if (e >= int'(k_eff_s)) begin
          elem_s = ident_s;
        end else begin
          elem_s = acc_t'(raw_s);
        end
        if (e == 0) begin
          row_s = elem_s;
        end else begin
          row_s = combine(mode_eff_s, row_s, elem_s);
        end
      end
      row_red_s[c] = row_s;
      if (first_s) begin
        acc_next_s[c] = row_s;
      end else begin
        acc_next_s[c] = combine(mode_eff_s, acc_r[c], row_s);
      end
      fin_s[c*DATA_W +: DATA_W] = finalise(mode_eff_s, shift_eff_s, acc_next_s[c]);
    end
  end

  // Beat counter, accumulators, latched config and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_r  <= {KW_W{1'b0}};
      cfg_k_r     <= KW_W'(1);
      cfg_mode_r  <= 2'd0;
      cfg_shift_r <= 5'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= {(CH*DATA_W){1'b0}};
      for (int c = 0; c < CH; c++) begin
        acc_r[c] <= {ACC_W{1'b0}};
      end
    end else begin
      if (accept_s) begin
        beat_cnt_r <= last_s ? {KW_W{1'b0}} : KW_W'(beat_cnt_r + KW_W'(1));
        for (int c = 0; c < CH; c++) begin
          acc_r[c] <= acc_next_s[c];
        end
        if (first_s) begin
          cfg_k_r     <= k_clamp_s;
          cfg_mode_r  <= bus.pool_mode;
          cfg_shift_r <= bus.mean_shift;
        end
      end
      if (accept_s && last_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= fin_s;
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.busy      = !first_s;
endmodule

// File: tb/tb_pool_mc.sv
// Randomised scoreboard bench for pool_mc: a window-level reference model pushes
// expected results; an independent monitor pops them at each output handshake.
module tb_pool_mc;
  localparam int DATA_W = 32;
  localparam int WIN    = 5;
  localparam int CH     = 4;
  localparam int BW     = CH*WIN*DATA_W;
  localparam int OW     = CH*DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pool_mc_if #(.DATA_W(DATA_W), .WIN(WIN), .CH(CH)) bus ();
  pool_mc #(.DATA_W(DATA_W), .WIN(WIN), .CH(CH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  int rdy_mode = 0;
  logic [OW-1:0] exp_q [$];
  logic [BW-1:0] win_beats [WIN];

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_el(input int r, input int c, input int e, input int v);
    win_beats[r][(c*WIN+e)*DATA_W +: DATA_W] = v;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < CH; c++)
        for (int e = 0; e < WIN; e++)
          case ($urandom_range(0, 3))
            0:       set_el(r, c, e, int'($urandom));
            1:       set_el(r, c, e, $urandom_range(0, 1) != 0 ? 32'h7FFFFFFF : 32'h80000000);
            2:       set_el(r, c, e, int'($urandom_range(0, 2000)) - 1000);
            default: set_el(r, c, e, int'($urandom_range(0, 20)) - 10);
          endcase
  endtask

  // Reference: gather the K x K elements of each channel and reduce them arithmetically.
  function automatic logic [OW-1:0] model(input int k, input int md, input int sh);
    logic [OW-1:0] res;
    longint s, v;
    int x;
    res = '0;
    for (int c = 0; c < CH; c++) begin
      x = win_beats[0][(c*WIN)*DATA_W +: DATA_W];
      s = (md >= 2) ? 64'sd0 : longint'(x);
      for (int r = 0; r < k; r++)
        for (int e = 0; e < k; e++) begin
          x = win_beats[r][(c*WIN+e)*DATA_W +: DATA_W];
          v = x;
          if (md == 0) s = (v > s) ? v : s;
          else if (md == 1) s = (v < s) ? v : s;
          else s = s + v;
        end
      if (md == 3) s = s >>> sh;
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
      res[c*DATA_W +: DATA_W] = s[31:0];
    end
    return res;
  endfunction

  task automatic send_beat(input logic [BW-1:0] data, input logic [2:0] kw, input logic [1:0] md,
                           input logic [4:0] sh, output bit ok);
    @(negedge clk);
    bus.in_data = data;
    bus.kernel_width = kw;
    bus.pool_mode = md;
    bus.mean_shift = sh;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      #2;
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL beat_accept: got in_ready=0 for 300 cycles expected acceptance");
    end
  endtask

  // Sends one window; beats after the first carry random config that must be ignored.
  task automatic run_window(input int kraw, input int md, input int sh);
    int k;
    bit ok;
    logic [OW-1:0] exp;
    k = (kraw == 0) ? 1 : (kraw > WIN ? WIN : kraw);
    exp = model(k, md, sh);
    for (int r = 0; r < k; r++) begin
      if (r == 0) send_beat(win_beats[r], 3'(kraw), 2'(md), 5'(sh), ok);
      else send_beat(win_beats[r], 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                     5'($urandom_range(0, 31)), ok);
      if (!ok) return;
    end
    exp_q.push_back(exp);
    @(negedge clk);
    #3;
    check("latency_valid", OW'(bus.out_valid), OW'(1'b1));
    check("busy_idle", OW'(bus.busy), OW'(1'b0));
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_left", OW'(exp_q.size()), OW'(0));
  endtask

  // Monitor: sets out_ready, checks hold while stalled and pops at each handshake.
  initial begin : monitor
    logic held;
    logic [OW-1:0] held_data;
    logic [OW-1:0] exp;
    held = 1'b0;
    held_data = '0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
      #2;
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) check("out_hold", bus.out_data, held_data);
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got %h expected none", bus.out_data);
          end else begin
            exp = exp_q.pop_front();
            check("result", bus.out_data, exp);
          end
        end
        held = bus.out_valid && !bus.out_ready;
        held_data = bus.out_data;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit ok;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.kernel_width = 3'd1;
    bus.pool_mode = 2'd0;
    bus.mean_shift = 5'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #3;
    check("rst_out_valid", OW'(bus.out_valid), OW'(1'b0));
    check("rst_out_data", bus.out_data, OW'(0));
    check("rst_in_ready", OW'(bus.in_ready), OW'(1'b1));
    check("rst_busy", OW'(bus.busy), OW'(1'b0));

    // MAX K=3, lane 0 rows {1,-7,4},{9,0,2},{-3,5,8}
    fill_rand();
    set_el(0, 0, 0, 1);  set_el(0, 0, 1, -7); set_el(0, 0, 2, 4);
    set_el(1, 0, 0, 9);  set_el(1, 0, 1, 0);  set_el(1, 0, 2, 2);
    set_el(2, 0, 0, -3); set_el(2, 0, 1, 5);  set_el(2, 0, 2, 8);
    run_window(3, 0, 0);
    // MIN K=2, masked elems driven to -100
    fill_rand();
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < 2; r++)
        for (int e = 2; e < WIN; e++) set_el(r, c, e, -100);
    set_el(0, 0, 0, 3);  set_el(0, 0, 1, 6);
    set_el(1, 0, 0, -2); set_el(1, 0, 1, 4);
    run_window(2, 1, 0);
    // MEAN extremes: saturating positive, flooring negative
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < CH; c++)
        for (int e = 0; e < WIN; e++) set_el(r, c, e, 32'h7FFFFFFF);
    run_window(3, 3, 3);
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < CH; c++)
        for (int e = 0; e < WIN; e++) set_el(r, c, e, -1);
    run_window(3, 3, 3);
    // SUM with K=0 (behaves as K=1), then a clamped K
    fill_rand();
    run_window(0, 2, 0);
    fill_rand();
    run_window(7, 2, 0);
    drain();

    // Backpressure: results held for 10 cycles while K=1 windows queue up
    rdy_mode = 2;
    fork
      begin
        for (int w = 0; w < 3; w++) begin
          fill_rand();
          run_window(1, w, 0);
        end
      end
      begin
        repeat (10) @(negedge clk);
        #3;
        check("bp_in_ready", OW'(bus.in_ready), OW'(1'b0));
        check("bp_out_valid", OW'(bus.out_valid), OW'(1'b1));
        rdy_mode = 0;
      end
    join
    drain();

    // Mid-window config changes ignored; reset discards a partial window
    fill_rand();
    run_window(3, 0, 0);
    drain();
    fill_rand();
    send_beat(win_beats[0], 3'd3, 2'd0, 5'd0, ok);
    @(negedge clk);
    #3;
    check("partial_busy", OW'(bus.busy), OW'(1'b1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #3;
    check("post_rst_valid", OW'(bus.out_valid), OW'(1'b0));
    check("post_rst_busy", OW'(bus.busy), OW'(1'b0));
    fill_rand();
    run_window(3, 2, 0);
    drain();

    // Random windows with random backpressure
    rdy_mode = 1;
    for (int n = 0; n < 120; n++) begin
      fill_rand();
      run_window($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 31));
    end
    drain();
    rdy_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
